// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue/retire sequencer: opcodes, opcode
// classes, controller states and NZCV bit positions.
package alu_pkg;

  localparam logic [4:0] OP_PASS = 5'b00000;
  localparam logic [4:0] OP_ADD  = 5'b00001;
  localparam logic [4:0] OP_SUB  = 5'b00010;
  localparam logic [4:0] OP_MUL  = 5'b00011;
  localparam logic [4:0] OP_MULH = 5'b00100;
  localparam logic [4:0] OP_CMP  = 5'b00101;
  localparam logic [4:0] OP_AND  = 5'b00110;
  localparam logic [4:0] OP_OR   = 5'b00111;
  localparam logic [4:0] OP_NOR  = 5'b01000;
  localparam logic [4:0] OP_NAND = 5'b01001;
  localparam logic [4:0] OP_XOR  = 5'b01010;
  localparam logic [4:0] OP_XNOR = 5'b01011;
  localparam logic [4:0] OP_NOT  = 5'b01100;
  localparam logic [4:0] OP_DIV  = 5'b01101;
  localparam logic [4:0] OP_MOD  = 5'b01110;
  localparam logic [4:0] OP_SHL  = 5'b11000;
  localparam logic [4:0] OP_SHR  = 5'b11001;
  localparam logic [4:0] OP_ASR  = 5'b11010;
  localparam logic [4:0] OP_ROR  = 5'b11011;

  localparam logic [1:0] CLS_SINGLE  = 2'd0;
  localparam logic [1:0] CLS_MUL     = 2'd1;
  localparam logic [1:0] CLS_DIV     = 2'd2;
  localparam logic [1:0] CLS_ILLEGAL = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DIV  = 2'd2,
    ST_RESP = 2'd3
  } state_t;

  localparam int NZCV_N = 3;
  localparam int NZCV_Z = 2;
  localparam int NZCV_C = 1;
  localparam int NZCV_V = 0;

  // Map an opcode onto its execution class (latency / execution unit).
  function automatic logic [1:0] op_class(input logic [4:0] op);
    logic [1:0] cls;
    case (op)
      OP_PASS, OP_ADD, OP_SUB, OP_CMP, OP_AND, OP_OR, OP_NOR, OP_NAND,
      OP_XOR, OP_XNOR, OP_NOT, OP_SHL, OP_SHR, OP_ASR, OP_ROR: cls = CLS_SINGLE;
      OP_MUL, OP_MULH: cls = CLS_MUL;
      OP_DIV, OP_MOD:  cls = CLS_DIV;
      default:         cls = CLS_ILLEGAL;
    endcase
    return cls;
  endfunction

  // Assemble a flag nibble in {N,Z,C,V} order.
  function automatic logic [3:0] pack_nzcv(input logic n, input logic z,
                                           input logic c, input logic v);
    logic [3:0] f;
    f         = '0;
    f[NZCV_N] = n;
    f[NZCV_Z] = z;
    f[NZCV_C] = c;
    f[NZCV_V] = v;
    return f;
  endfunction

endpackage

// File: rtl/seq_divider.sv
// Iterative unsigned restoring divider. The start cycle already performs the
// first quotient step from the x/y inputs, so done pulses WIDTH cycles after
// start. A zero divisor is flagged combinationally in the start cycle.
module seq_divider
  import alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic             done,
  output logic [WIDTH-1:0] quo,
  output logic [WIDTH-1:0] rem,
  output logic             div0
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] rem_reg, quo_reg, dvs_reg;
  logic [CW-1:0]    cnt_reg;
  logic             busy_reg, done_reg;

  logic [WIDTH-1:0] src_rem, src_quo, src_dvs;
  logic [WIDTH:0]   trial;
  logic             fits;
  logic [WIDTH-1:0] rem_next, quo_next;

  // One restoring step: shift in the next dividend bit, subtract if it fits.
  always_comb begin
    src_rem  = start ? '0 : rem_reg;
    src_quo  = start ? x  : quo_reg;
    src_dvs  = start ? y  : dvs_reg;
    trial    = {src_rem, src_quo[WIDTH-1]};
    fits     = (trial >= {1'b0, src_dvs});
    rem_next = fits ? (trial[WIDTH-1:0] - src_dvs) : trial[WIDTH-1:0];
    quo_next = {src_quo[WIDTH-2:0], fits};
  end

  // Iteration registers: load-and-step on start, then step until the count expires.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rem_reg  <= '0;
      quo_reg  <= '0;
      dvs_reg  <= '0;
      cnt_reg  <= '0;
      busy_reg <= 1'b0;
      done_reg <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      if (start && (y != '0)) begin
        rem_reg  <= rem_next;
        quo_reg  <= quo_next;
        dvs_reg  <= y;
        cnt_reg  <= CW'(WIDTH - 1);
        busy_reg <= 1'b1;
      end else if (busy_reg) begin
        rem_reg <= rem_next;
        quo_reg <= quo_next;
        cnt_reg <= cnt_reg - 1'b1;
        if (cnt_reg == CW'(1)) begin
          busy_reg <= 1'b0;
          done_reg <= 1'b1;
        end
      end
    end
  end

  assign done = done_reg;
  assign quo  = quo_reg;
  assign rem  = rem_reg;
  assign div0 = start && (y == '0);

endmodule

// File: rtl/alu_sequencer.sv
// Issue/retire controller for the combinational ALU: accepts one request,
// holds its operands on the ALU for the opcode latency (or runs the iterative
// divider), then presents the result and flags until the consumer takes it.
module alu_sequencer
  import alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [4:0]       req_opcode,
  input  logic [WIDTH-1:0] req_x,
  input  logic [WIDTH-1:0] req_y,
  output logic [4:0]       alu_opcode,
  output logic [WIDTH-1:0] alu_x,
  output logic [WIDTH-1:0] alu_y,
  input  logic [WIDTH-1:0] alu_r,
  input  logic             alu_n,
  input  logic             alu_z,
  input  logic             alu_c,
  input  logic             alu_v,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [WIDTH-1:0] resp_r,
  output logic [3:0]       resp_nzcv,
  output logic             resp_div_invalid,
  output logic             resp_illegal,
  output logic [3:0]       flags_nzcv,
  output logic             busy,
  output logic [15:0]      ops_retired
);

  state_t           state_reg, state_next;
  logic [4:0]       opcode_reg;
  logic [WIDTH-1:0] x_reg, y_reg;
  logic             cnt_reg;
  logic             start_reg;
  logic [WIDTH-1:0] resp_r_reg;
  logic [3:0]       resp_nzcv_reg, flags_reg;
  logic             div_inv_reg, illegal_reg;
  logic [15:0]      retired_reg;

  logic [1:0]       req_cls;
  logic             div_done, div_zero;
  logic [WIDTH-1:0] div_quo, div_rem, div_res;
  logic [3:0]       div_nzcv, alu_nzcv;

  assign req_cls  = op_class(req_opcode);
  assign div_res  = (opcode_reg == OP_DIV) ? div_quo : div_rem;
  assign div_nzcv = pack_nzcv(div_res[WIDTH-1], div_res == '0, 1'b0, 1'b0);
  assign alu_nzcv = pack_nzcv(alu_n, alu_z, alu_c, alu_v);

  seq_divider #(.WIDTH(WIDTH)) u_div (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start_reg),
    .x     (x_reg),
    .y     (y_reg),
    .done  (div_done),
    .quo   (div_quo),
    .rem   (div_rem),
    .div0  (div_zero)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state_reg <= ST_IDLE;
    else        state_reg <= state_next;
  end

  // Next-state selection.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: if (req_valid) begin
        case (req_cls)
          CLS_ILLEGAL: state_next = ST_RESP;
          CLS_DIV:     state_next = ST_DIV;
          default:     state_next = ST_EXEC;
        endcase
      end
      ST_EXEC: if (cnt_reg == 1'b0) state_next = ST_RESP;
      ST_DIV:  if (div_zero || div_done) state_next = ST_RESP;
      ST_RESP: if (resp_ready) state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Handshake and status outputs decoded from the state.
  always_comb begin
    req_ready  = (state_reg == ST_IDLE);
    resp_valid = (state_reg == ST_RESP);
    busy       = (state_reg != ST_IDLE);
  end

  // Operand capture, result capture, architectural flags and retire counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      opcode_reg    <= '0;
      x_reg         <= '0;
      y_reg         <= '0;
      cnt_reg       <= 1'b0;
      start_reg     <= 1'b0;
      resp_r_reg    <= '0;
      resp_nzcv_reg <= '0;
      div_inv_reg   <= 1'b0;
      illegal_reg   <= 1'b0;
      flags_reg     <= '0;
      retired_reg   <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: if (req_valid) begin
          opcode_reg  <= req_opcode;
          x_reg       <= req_x;
          y_reg       <= req_y;
          cnt_reg     <= (req_cls == CLS_MUL);
          start_reg   <= (req_cls == CLS_DIV);
          div_inv_reg <= 1'b0;
          illegal_reg <= (req_cls == CLS_ILLEGAL);
          if (req_cls == CLS_ILLEGAL) begin
            resp_r_reg    <= '0;
            resp_nzcv_reg <= '0;
          end
        end
        ST_EXEC: begin
          if (cnt_reg == 1'b0) begin
            // Compare only produces flags; its difference is not a result.
            resp_r_reg    <= (opcode_reg == OP_CMP) ? '0 : alu_r;
            resp_nzcv_reg <= alu_nzcv;
            flags_reg     <= alu_nzcv;
          end else begin
            cnt_reg <= 1'b0;
          end
        end
        ST_DIV: begin
          start_reg <= 1'b0;
          if (div_zero) begin
            resp_r_reg    <= (opcode_reg == OP_DIV) ? '1 : x_reg;
            resp_nzcv_reg <= '0;
            div_inv_reg   <= 1'b1;
          end else if (div_done) begin
            resp_r_reg    <= div_res;
            resp_nzcv_reg <= div_nzcv;
            flags_reg     <= div_nzcv;
          end
        end
        ST_RESP: if (resp_ready) retired_reg <= retired_reg + 16'd1;
        default: ;
      endcase
    end
  end

  assign alu_opcode       = opcode_reg;
  assign alu_x            = x_reg;
  assign alu_y            = y_reg;
  assign resp_r           = resp_r_reg;
  assign resp_nzcv        = resp_nzcv_reg;
  assign resp_div_invalid = div_inv_reg;
  assign resp_illegal     = illegal_reg;
  assign flags_nzcv       = flags_reg;
  assign ops_retired      = retired_reg;

endmodule

// File: tb/tb_alu_sequencer.sv
// Randomised scoreboard bench for alu_sequencer with a behavioural ALU model
// attached to the alu_* port and a high-level reference for every response.
module tb_alu_sequencer;

  logic        clk, rst_n;
  logic        req_valid, req_ready;
  logic [4:0]  req_opcode;
  logic [15:0] req_x, req_y;
  logic [4:0]  alu_opcode;
  logic [15:0] alu_x, alu_y, alu_r;
  logic        alu_n, alu_z, alu_c, alu_v;
  logic        resp_valid, resp_ready;
  logic [15:0] resp_r;
  logic [3:0]  resp_nzcv, flags_nzcv;
  logic        resp_div_invalid, resp_illegal, busy;
  logic [15:0] ops_retired;

  alu_sequencer #(.WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_opcode(req_opcode),
    .req_x(req_x), .req_y(req_y),
    .alu_opcode(alu_opcode), .alu_x(alu_x), .alu_y(alu_y), .alu_r(alu_r),
    .alu_n(alu_n), .alu_z(alu_z), .alu_c(alu_c), .alu_v(alu_v),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_r(resp_r),
    .resp_nzcv(resp_nzcv), .resp_div_invalid(resp_div_invalid),
    .resp_illegal(resp_illegal), .flags_nzcv(flags_nzcv), .busy(busy),
    .ops_retired(ops_retired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] r;
    logic [3:0]  nzcv;
    logic        inv;
    logic        ill;
    logic [3:0]  flags;
    int          acc;
    int          lat;
  } exp_t;

  exp_t        sbq[$];
  exp_t        cur;
  int          tests = 0, fails = 0;
  int          cyc = 0;
  int          age = 0;
  logic [36:0] last_in = '0;
  logic [3:0]  arch = 4'b0000;
  logic [15:0] exp_retired = 16'd0;
  logic        in_resp = 1'b0;
  int          run = 0;
  int          rr_mode = 1;   // 0 random, 1 always ready, 2 stall 5 RESP cycles

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Behavioural ALU: {r, n, z, c, v}
  function automatic logic [19:0] alu_fn(input logic [4:0] op, input logic [15:0] x,
                                         input logic [15:0] y);
    logic [15:0] r; logic c, v; logic [16:0] s; logic [31:0] p;
    c = 1'b0; v = 1'b0; p = x * y; s = '0;
    case (op)
      5'd0:  r = x;
      5'd1:  begin s = {1'b0, x} + {1'b0, y}; r = s[15:0]; c = s[16];
               v = (x[15] == y[15]) && (r[15] != x[15]); end
      5'd2, 5'd5: begin r = x - y; c = (x >= y); v = (x[15] != y[15]) && (r[15] != x[15]); end
      5'd3:  r = p[15:0];
      5'd4:  r = p[31:16];
      5'd6:  r = x & y;
      5'd7:  r = x | y;
      5'd8:  r = ~(x | y);
      5'd9:  r = ~(x & y);
      5'd10: r = x ^ y;
      5'd11: r = ~(x ^ y);
      5'd12: r = ~x;
      5'd24: r = x << y[3:0];
      5'd25: r = x >> y[3:0];
      5'd26: r = $signed(x) >>> y[3:0];
      5'd27: r = (x >> y[3:0]) | (x << (16 - y[3:0]));
      default: r = 16'h0;
    endcase
    return {r, r[15], r == 16'h0, c, v};
  endfunction

  // ALU inputs must stay stable for two cycles before a multiply result is good.
  always @(negedge clk) begin
    if ({alu_opcode, alu_x, alu_y} !== last_in) age = 0;
    else if (age < 100) age = age + 1;
    last_in = {alu_opcode, alu_x, alu_y};
  end

  always_comb begin
    {alu_r, alu_n, alu_z, alu_c, alu_v} = alu_fn(alu_opcode, alu_x, alu_y);
    if ((alu_opcode == 5'd3 || alu_opcode == 5'd4) && age == 0) alu_r = alu_r ^ 16'h5A5A;
  end

  // Reference result for a request, from the opcode-class rules.
  function automatic exp_t model(input logic [4:0] op, input logic [15:0] x, input logic [15:0] y);
    exp_t e; logic [19:0] a; logic [15:0] q;
    e.inv = 1'b0; e.ill = 1'b0; e.acc = 0;
    a = alu_fn(op, x, y);
    if (op inside {5'd0, 5'd1, 5'd2, 5'd5, [5'd6:5'd12], [5'd24:5'd27]}) begin
      e.lat = 2; e.r = (op == 5'd5) ? 16'h0 : a[19:4]; e.nzcv = a[3:0];
    end else if (op == 5'd3 || op == 5'd4) begin
      e.lat = 3; e.r = a[19:4]; e.nzcv = a[3:0];
    end else if (op == 5'd13 || op == 5'd14) begin
      if (y == 16'h0) begin
        e.lat = 2; e.inv = 1'b1; e.nzcv = 4'b0000;
        e.r = (op == 5'd13) ? 16'hFFFF : x;
      end else begin
        e.lat = 18;
        q = (op == 5'd13) ? x / y : x % y;
        e.r = q; e.nzcv = {q[15], q == 16'h0, 2'b00};
      end
    end else begin
      e.lat = 1; e.ill = 1'b1; e.r = 16'h0; e.nzcv = 4'b0000;
    end
    return e;
  endfunction

  task automatic issue(input logic [4:0] op, input logic [15:0] x, input logic [15:0] y);
    exp_t e; int n;
    req_valid = 1'b1; req_opcode = op; req_x = x; req_y = y;
    n = 0;
    while (!req_ready && n < 300) begin @(negedge clk); n++; end
    if (!req_ready) begin
      tests++; fails++;
      $display("FAIL accept_timeout: req_ready stuck at 0, expected 1");
      req_valid = 1'b0;
      return;
    end
    e = model(op, x, y);
    e.acc = cyc;
    if (!e.ill && !e.inv) arch = e.nzcv;
    e.flags = arch;
    sbq.push_back(e);
    $display("[TB] issue op=%b x=%h y=%h -> r=%h nzcv=%b lat=%0d", op, x, y, e.r, e.nzcv, e.lat);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  // Monitor: pops the scoreboard on each new response and checks it while held.
  always @(negedge clk) begin
    if (!rst_n) begin
      in_resp = 1'b0; exp_retired = 16'd0; resp_ready = 1'b0;
    end else begin
      chk("ops_retired", {16'h0, ops_retired}, {16'h0, exp_retired});
      if (resp_valid) begin
        if (!in_resp) begin
          if (sbq.size() == 0) begin
            tests++; fails++;
            $display("FAIL unexpected_resp: resp_valid=1 with r=%h, expected no response", resp_r);
          end else begin
            cur = sbq.pop_front();
            chk("latency", cyc - cur.acc, cur.lat);
            chk("resp_r", {16'h0, resp_r}, {16'h0, cur.r});
            chk("resp_nzcv", {28'h0, resp_nzcv}, {28'h0, cur.nzcv});
            chk("div_invalid", {31'h0, resp_div_invalid}, {31'h0, cur.inv});
            chk("illegal", {31'h0, resp_illegal}, {31'h0, cur.ill});
            chk("flags_nzcv", {28'h0, flags_nzcv}, {28'h0, cur.flags});
            $display("[TB] resp r=%h nzcv=%b inv=%b ill=%b flags=%b", resp_r, resp_nzcv,
                     resp_div_invalid, resp_illegal, flags_nzcv);
          end
          in_resp = 1'b1; run = 0;
        end else begin
          chk("hold_r", {16'h0, resp_r}, {16'h0, cur.r});
          chk("hold_nzcv", {28'h0, resp_nzcv}, {28'h0, cur.nzcv});
        end
        chk("req_ready_in_resp", {31'h0, req_ready}, 32'h0);
        run++;
        if (rr_mode == 0)      resp_ready = 1'($urandom_range(0, 1));
        else if (rr_mode == 1) resp_ready = 1'b1;
        else                   resp_ready = (run > 5);
        if (resp_ready) begin in_resp = 1'b0; exp_retired = exp_retired + 16'd1; end
      end else begin
        if (in_resp) begin
          tests++; fails++;
          $display("FAIL resp_dropped: resp_valid=0 expected 1");
          in_resp = 1'b0;
        end
        resp_ready = (rr_mode == 0) ? 1'($urandom_range(0, 1)) : 1'b1;
      end
    end
  end

  initial begin
    logic [4:0] op;
    logic [15:0] x, y;
    int n;
    rst_n = 1'b0; req_valid = 1'b0; req_opcode = '0; req_x = '0; req_y = '0;
    repeat (3) @(negedge clk);
    chk("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
    chk("rst_busy", {31'h0, busy}, 32'h0);
    chk("rst_ops_retired", {16'h0, ops_retired}, 32'h0);
    chk("rst_flags", {28'h0, flags_nzcv}, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // Reset during a divide: the operation is dropped and never retires.
    issue(5'd13, 16'h4321, 16'h0003);
    repeat (6) @(negedge clk);
    rst_n = 1'b0;
    sbq.delete();
    arch = 4'b0000;
    @(negedge clk);
    chk("midrst_resp_valid", {31'h0, resp_valid}, 32'h0);
    chk("midrst_busy", {31'h0, busy}, 32'h0);
    chk("midrst_retired", {16'h0, ops_retired}, 32'h0);
    chk("midrst_resp_r", {16'h0, resp_r}, 32'h0);
    chk("midrst_alu_x", {16'h0, alu_x}, 32'h0);
    chk("midrst_alu_opcode", {27'h0, alu_opcode}, 32'h0);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);

    // Directed cases with the consumer always ready.
    rr_mode = 1;
    issue(5'd1, 16'h7FFF, 16'h0001);
    issue(5'd13, 16'd100, 16'd7);
    issue(5'd14, 16'd100, 16'd7);
    issue(5'd13, 16'h1234, 16'h0000);
    issue(5'd14, 16'h1234, 16'h0000);
    issue(5'b10000, 16'h5555, 16'h1111);
    issue(5'd3, 16'h0123, 16'h0456);
    issue(5'd5, 16'h0003, 16'h0009);

    // Consumer stalls 5 cycles on a subtract while the next request waits.
    rr_mode = 2;
    issue(5'd2, 16'd5, 16'd7);
    issue(5'd1, 16'd1, 16'd2);
    rr_mode = 1;

    // Randomised traffic with a randomly stalling consumer.
    rr_mode = 0;
    for (int i = 0; i < 60; i++) begin
      op = 5'($urandom_range(0, 31));
      x  = 16'($urandom);
      y  = ($urandom_range(0, 7) == 0) ? 16'h0 : 16'($urandom);
      issue(op, x, y);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    n = 0;
    while ((sbq.size() != 0 || in_resp) && n < 1000) begin @(negedge clk); n++; end
    if (sbq.size() != 0 || in_resp) begin
      tests++; fails++;
      $display("FAIL drain_timeout: %0d responses outstanding, expected 0", sbq.size());
    end
    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/alu_sequencer.md
# alu_sequencer

Issue/retire controller for the 16-bit combinational ALU. Accepts one operation at a time over a valid/ready request port. Registers the operands and drives them onto the ALU. Waits the per-opcode latency and captures the result and the NZCV flags into a response register and an architectural flag register. Division and modulo bypass the ALU's combinational divider and run in an internal iterative divider; all other opcodes use the ALU.

## Interface
- WIDTH, 16, datapath width of operands and result
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  sequencer can accept
- req_opcode  in  5  ALU opcode
- req_x, req_y  in  WIDTH  operands
- alu_opcode  out  5  registered opcode to ALU
- alu_x, alu_y  out  WIDTH  registered operands to ALU
- alu_r  in  WIDTH  ALU result
- alu_n, alu_z, alu_c, alu_v  in  1  ALU flags
- resp_valid  out  1  result available
- resp_ready  in  1  consumer takes result
- resp_r  out  WIDTH  result
- resp_nzcv  out  4  flags of this op, {N,Z,C,V}
- resp_div_invalid  out  1  divide/modulo by zero
- resp_illegal  out  1  unsupported opcode
- flags_nzcv  out  4  architectural flag register
- busy  out  1  not IDLE
- ops_retired  out  16  completed-response counter, wraps

## Operation
- Opcode classes:
  - Single (1 exec cycle): 00000 pass, 00001 add, 00010 sub, 00101 compare, 00110 and, 00111 or, 01000 nor, 01001 nand, 01010 xor, 01011 xnor, 01100 not, 11000–11011 shifts.
  - Multiply (2 exec cycles): 00011, 00100.
  - Divide: 01101 quotient, 01110 remainder.
  - Illegal: all other opcodes.
- States: IDLE, EXEC, DIV, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid: register opcode/x/y and go to EXEC, or to DIV for the divide class.
  - Illegal opcode goes to RESP directly with r=0, nzcv=0, resp_illegal=1.
- EXEC: count down the class latency. On the last cycle, sample alu_r and the ALU flags into the response register, then go to RESP.
  - Compare: resp_r forced to 0; flags come from the ALU.
- DIV: unsigned restoring divide, one quotient bit per cycle, WIDTH cycles.
  - Result N = r[WIDTH-1], Z = (r==0), C = 0, V = 0.
  - y==0: skip the iteration and leave DIV after 1 cycle with quotient all-ones (or remainder = x), nzcv=0, resp_div_invalid=1.
- RESP:
  - resp_valid=1 and all resp_* outputs held stable until resp_ready. On resp_valid&&resp_ready, go to IDLE and increment ops_retired.
  - resp_ready already high on the first RESP cycle: retire in that cycle.
  - A new request is not accepted in the retire cycle; it is accepted in the following IDLE cycle.
- flags_nzcv: written with resp_nzcv when entering RESP. Not written for illegal opcodes or division by zero.
- alu_* outputs hold the last accepted request outside EXEC.
- Reset: every output goes to 0 and state to IDLE, including mid-EXEC/DIV/RESP. Any in-flight op is discarded and not counted.

## Timing
- Let E0 be the accept edge (req_valid && req_ready). resp_valid first rises after:
  - E0+2 for single-cycle ops
  - E0+3 for multiply
  - E0+WIDTH+2 for divide
  - E0+2 for divide-by-zero
  - E0+1 for illegal opcodes
- Minimum initiation interval: single-cycle op with resp_ready held high is 3 cycles.
- req_ready is 0 from E0 until the retire edge, exclusive of IDLE.
- ops_retired updates on the retire edge. 0xFFFF wraps to 0x0000.

## Structure
- Shared package alu_pkg holds:
  - opcode localparams (OP_PASS … OP_ROR)
  - class encoding (CLS_SINGLE, CLS_MUL, CLS_DIV, CLS_ILLEGAL) and a decode function opcode→class
  - state enum
  - NZCV bit index constants
- One sub-module: seq_divider (start, x, y → done, quo, rem, div0).
  - Iterative restoring, WIDTH-parameterised.
  - Synchronous active-low reset on rst_n.

## Test plan
- add 0x7FFF+0x0001, resp_ready=1 → resp_r=0x8000, nzcv=1001, resp_valid 2 cycles after accept, flags_nzcv=1001.
- div 100/7 then mod 100/7 → quotient 0x000E at E0+18, then remainder 0x0002; ops_retired increments by 2.
- div 0x1234/0 → resp_r=0xFFFF, resp_div_invalid=1, at E0+2; flags_nzcv keeps its prior value.
- opcode 10000 → resp_illegal=1, resp_r=0 at E0+1; flags unchanged.
- Hold resp_ready=0 for 5 cycles after a sub (5−7): resp_r=0xFFFE and nzcv stay stable, req_ready=0, and a pending req_valid is not accepted until the cycle after the retire edge.
- Drop rst_n in cycle 8 of a divide → next edge all outputs 0, state IDLE, ops_retired unchanged from 0, and no resp_valid.
